// File: rtl/decode_stage_ras_if.sv
// Decode-stage bus: fetch-side inputs, write-back port, EX flags and the
// ID/EX outputs. The design uses the slave modport, its driver the master.
interface decode_stage_ras_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 22,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] next_pc;
  logic              instr_valid;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_zero;
  logic              ex_neg;
  logic              ex_ov;

  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic [2:0]        ex_alu_op;
  logic [16:0]       ex_imm;
  logic [DATA_W-1:0] ex_s_data;
  logic [DATA_W-1:0] ex_t_data;
  logic [4:0]        ex_dst_reg;
  logic              ex_use_dst_reg;
  logic              ex_use_imm;
  logic              ex_mem_re;
  logic              ex_mem_we;
  logic [3:0]        ex_upd_flags;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_underflow;
  logic              halted;

  modport slave (
    input  instr, pc_in, next_pc, instr_valid, flush, wb_we, wb_addr, wb_data,
           ex_zero, ex_neg, ex_ov,
    output stall, branch_taken, branch_addr, ex_valid, ex_pc, ex_alu_op, ex_imm,
           ex_s_data, ex_t_data, ex_dst_reg, ex_use_dst_reg, ex_use_imm,
           ex_mem_re, ex_mem_we, ex_upd_flags, ras_count, ras_underflow, halted
  );

  modport master (
    output instr, pc_in, next_pc, instr_valid, flush, wb_we, wb_addr, wb_data,
           ex_zero, ex_neg, ex_ov,
    input  stall, branch_taken, branch_addr, ex_valid, ex_pc, ex_alu_op, ex_imm,
           ex_s_data, ex_t_data, ex_dst_reg, ex_use_dst_reg, ex_use_imm,
           ex_mem_re, ex_mem_we, ex_upd_flags, ras_count, ras_underflow, halted
  );
endinterface

// File: rtl/decode_stage_ras.sv
// Decode stage: register file with WB bypass, ID/EX register, branch/jump
// resolution with a circular return-address stack, load-use stall and HALT.
module decode_stage_ras #(
  parameter int         DATA_W    = 32,
  parameter int         ADDR_W    = 22,
  parameter int         RAS_DEPTH = 4,
  parameter logic [4:0] RA_REG    = 5'h1D
) (
  input logic               clk,
  input logic               rst_n,
  decode_stage_ras_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010, OP_SUBI = 5'b00011;
  localparam logic [4:0] OP_LW   = 5'b00100, OP_SW   = 5'b00101;
  localparam logic [4:0] OP_MOV  = 5'b00110, OP_MOVI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000, OP_OR   = 5'b01001;
  localparam logic [4:0] OP_NOR  = 5'b01010, OP_SLL  = 5'b01011;
  localparam logic [4:0] OP_SRL  = 5'b01100, OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_B    = 5'b01110, OP_JR   = 5'b10000;
  localparam logic [4:0] OP_JAL  = 5'b10001, OP_HALT = 5'b11111;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
  endfunction

  function automatic logic cond_ok(input logic [2:0] c, input logic z, input logic n,
                                   input logic v);
    logic r;
    r = 1'b0;
    case (c)
      3'b000:  r = !z;
      3'b001:  r = z;
      3'b010:  r = !n && !z;
      3'b011:  r = n && !z;
      3'b100:  r = !n || z;
      3'b101:  r = n || z;
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] regs [32];
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_wp;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_unf_r;
  logic              halted_r;

  logic              vld_p1;
  logic [ADDR_W-1:0] ex_pc_p1;
  logic [2:0]        ex_alu_op_p1;
  logic [16:0]       ex_imm_p1;
  logic [DATA_W-1:0] ex_s_data_p1, ex_t_data_p1;
  logic [4:0]        ex_dst_p1;
  logic              ex_use_dst_p1, ex_use_imm_p1, ex_mem_re_p1, ex_mem_we_p1;
  logic [3:0]        ex_upd_p1;

  logic [4:0]  op, rd, rs, rt, s_sel, t_sel;
  logic [2:0]  alu_op;
  logic [3:0]  upd;
  logic        use_s, use_t, use_dst, use_imm, mem_re, mem_we;
  logic        is_b, is_jal, is_jr, is_halt, issues;
  logic [DATA_W-1:0] s_data, t_data;
  logic [ADDR_W-1:0] label_addr, ras_top;
  logic        load_use, stall, act, ra_pop, ras_push, ras_pop;

  assign op         = bus.instr[31:27];
  assign rd         = bus.instr[26:22];
  assign rs         = bus.instr[21:17];
  assign rt         = bus.instr[16:12];
  assign label_addr = ADDR_W'(bus.instr[21:0]);

  // Opcode decode: control fields and which source registers are really read.
  always_comb begin
    s_sel = rs;    t_sel = rt;
    use_s = 1'b0;  use_t = 1'b0;
    alu_op = 3'b000; upd = 4'b0000;
    use_dst = 1'b0; use_imm = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    is_b = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_halt = 1'b0; issues = 1'b1;
    case (op)
      OP_ADD:  begin upd = 4'b1111; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_ADDI: begin upd = 4'b1111; use_s = 1'b1; use_dst = 1'b1; use_imm = 1'b1; end
      OP_SUB:  begin alu_op = 3'b001; upd = 4'b1111; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_SUBI: begin alu_op = 3'b001; upd = 4'b1111; use_s = 1'b1; use_dst = 1'b1; use_imm = 1'b1; end
      OP_AND:  begin alu_op = 3'b010; upd = 4'b0001; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_OR:   begin alu_op = 3'b011; upd = 4'b0001; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_NOR:  begin alu_op = 3'b100; upd = 4'b0001; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_SLL:  begin alu_op = 3'b101; upd = 4'b0011; use_s = 1'b1; use_dst = 1'b1; use_imm = 1'b1; end
      OP_SRL:  begin alu_op = 3'b110; upd = 4'b0001; use_s = 1'b1; use_dst = 1'b1; use_imm = 1'b1; end
      OP_SRA:  begin alu_op = 3'b111; upd = 4'b0001; use_s = 1'b1; use_dst = 1'b1; use_imm = 1'b1; end
      OP_LW:   begin mem_re = 1'b1; use_s = 1'b1; use_t = 1'b1; use_dst = 1'b1; end
      OP_SW:   begin mem_we = 1'b1; t_sel = rd; use_s = 1'b1; use_t = 1'b1; use_imm = 1'b1; end
      OP_MOV:  begin t_sel = 5'd0; use_s = 1'b1; use_dst = 1'b1; end
      OP_MOVI: begin s_sel = 5'd0; use_dst = 1'b1; use_imm = 1'b1; end
      OP_B:    begin is_b = 1'b1; use_imm = 1'b1; issues = 1'b0; end
      OP_JR:   begin s_sel = rd; use_s = 1'b1; is_jr = 1'b1; issues = 1'b0; end
      OP_JAL:  begin is_jal = 1'b1; use_imm = 1'b1; issues = 1'b0; end
      OP_HALT: begin is_halt = 1'b1; issues = 1'b0; end
      default: ;
    endcase
  end

  // Register reads: r0 is hard zero, a same-cycle write-back is bypassed.
  always_comb begin
    s_data = '0;
    t_data = '0;
    if (s_sel != 5'd0)
      s_data = (bus.wb_we && bus.wb_addr == s_sel) ? bus.wb_data : regs[s_sel];
    if (t_sel != 5'd0)
      t_data = (bus.wb_we && bus.wb_addr == t_sel) ? bus.wb_data : regs[t_sel];
  end

  // A flushed instruction needs no hold, so only halt can stall under flush.
  assign load_use = bus.instr_valid && vld_p1 && ex_mem_re_p1 && (ex_dst_p1 != 5'd0) &&
                    ((use_s && s_sel == ex_dst_p1) || (use_t && t_sel == ex_dst_p1));
  assign stall    = halted_r || (load_use && !bus.flush);
  assign act      = rst_n && bus.instr_valid && !bus.flush && !stall;
  assign ra_pop   = is_jr && (rd == RA_REG);
  assign ras_push = act && is_jal;
  assign ras_pop  = act && ra_pop;
  assign ras_top  = ras_mem[ptr_dec(ras_wp)];

  // Redirect target: label for B/JAL, stack top for an RA return, else rs.
  always_comb begin
    bus.branch_addr = label_addr;
    if (is_jr)
      bus.branch_addr = (ra_pop && ras_cnt != '0) ? ras_top : s_data[ADDR_W-1:0];
  end

  assign bus.branch_taken = act && ((is_b && cond_ok(bus.instr[26:24], bus.ex_zero,
                                     bus.ex_neg, bus.ex_ov)) || is_jal || is_jr);

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Return-address stack: circular, oldest entry overwritten when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      ras_wp    <= '0;
      ras_cnt   <= '0;
      ras_unf_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      ras_unf_r <= ras_pop && (ras_cnt == '0);
      if (ras_push) begin
        ras_mem[ras_wp] <= bus.next_pc;
        ras_wp          <= ptr_inc(ras_wp);
        ras_cnt         <= cnt_sat_inc(ras_cnt);
      end else if (ras_pop && ras_cnt != '0) begin
        ras_wp  <= ptr_dec(ras_wp);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
      if (act && is_halt) halted_r <= 1'b1;
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0; ex_pc_p1 <= '0; ex_alu_op_p1 <= '0; ex_imm_p1 <= '0;
      ex_s_data_p1 <= '0; ex_t_data_p1 <= '0; ex_dst_p1 <= '0;
      ex_use_dst_p1 <= 1'b0; ex_use_imm_p1 <= 1'b0;
      ex_mem_re_p1 <= 1'b0; ex_mem_we_p1 <= 1'b0; ex_upd_p1 <= '0;
    end else begin
      vld_p1 <= act && issues;
      if (act) begin
        ex_pc_p1 <= bus.pc_in; ex_alu_op_p1 <= alu_op; ex_imm_p1 <= bus.instr[16:0];
        ex_s_data_p1 <= s_data; ex_t_data_p1 <= t_data; ex_dst_p1 <= rd;
        ex_use_dst_p1 <= use_dst; ex_use_imm_p1 <= use_imm;
        ex_mem_re_p1 <= mem_re; ex_mem_we_p1 <= mem_we; ex_upd_p1 <= upd;
      end
    end
  end

  assign bus.stall          = stall;
  assign bus.ex_valid       = vld_p1;
  assign bus.ex_pc          = ex_pc_p1;
  assign bus.ex_alu_op      = ex_alu_op_p1;
  assign bus.ex_imm         = ex_imm_p1;
  assign bus.ex_s_data      = ex_s_data_p1;
  assign bus.ex_t_data      = ex_t_data_p1;
  assign bus.ex_dst_reg     = ex_dst_p1;
  assign bus.ex_use_dst_reg = ex_use_dst_p1;
  assign bus.ex_use_imm     = ex_use_imm_p1;
  assign bus.ex_mem_re      = ex_mem_re_p1;
  assign bus.ex_mem_we      = ex_mem_we_p1;
  assign bus.ex_upd_flags   = ex_upd_p1;
  assign bus.ras_count      = ras_cnt;
  assign bus.ras_underflow  = ras_unf_r;
  assign bus.halted         = halted_r;
endmodule

// File: tb/tb_decode_stage_ras.sv
// Directed bench for decode_stage_ras: table of single-instruction vectors
// plus hand sequences for bypass, load-use, RAS, flush, HALT and reset.
module tb_decode_stage_ras;
  localparam int DATA_W = 32, ADDR_W = 22, RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  decode_stage_ras_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();
  decode_stage_ras #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH),
                     .RA_REG(5'h1D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        z, n, v;
    logic        taken;
    logic [21:0] baddr;
    logic        valid;
    logic [2:0]  alu;
    logic [31:0] s, t;
    logic [4:0]  dst;
    logic        ud, ui, re, we;
    logic [3:0]  upd;
    logic [16:0] imm;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] c, input logic [21:0] lbl);
    return {5'b01110, c, 2'b00, lbl};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [21:0] lbl);
    return {5'b10001, 5'd0, lbl};
  endfunction

  task automatic add(input logic [31:0] instr, input logic z, n, v, input logic tk,
                     input logic [21:0] ba, input logic vl, input logic [2:0] alu,
                     input logic [31:0] s, t, input logic [4:0] dst,
                     input logic ud, ui, re, we, input logic [3:0] upd, input logic [16:0] imm);
    vec_t e;
    e.instr = instr; e.z = z; e.n = n; e.v = v; e.taken = tk; e.baddr = ba;
    e.valid = vl; e.alu = alu; e.s = s; e.t = t; e.dst = dst;
    e.ud = ud; e.ui = ui; e.re = re; e.we = we; e.upd = upd; e.imm = imm;
    vq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.instr_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick();
    bus.wb_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.instr = '0; bus.pc_in = '0; bus.next_pc = '0; bus.instr_valid = 1'b0;
    bus.flush = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_zero = 1'b0; bus.ex_neg = 1'b0; bus.ex_ov = 1'b0;

    //        instr                               z n v tk baddr    vl alu s      t      dst  ud ui re we upd  imm
    add(enc_r(5'b00000, 5'd3, 5'd1, 5'd2),        0,0,0, 0, 0,       1, 0, 5,     7,     3,   1, 0, 0, 0, 4'hF, 17'h02000);
    add(enc_i(5'b00011, 5'd4, 5'd2, 17'h10),      0,0,0, 0, 0,       1, 1, 7,     0,     4,   1, 1, 0, 0, 4'hF, 17'h00010);
    add(enc_r(5'b01000, 5'd5, 5'd1, 5'd6),        0,0,0, 0, 0,       1, 2, 5,     32'h33,5,   1, 0, 0, 0, 4'h1, 17'h06000);
    add(enc_r(5'b01001, 5'd5, 5'd6, 5'd2),        0,0,0, 0, 0,       1, 3, 32'h33,7,     5,   1, 0, 0, 0, 4'h1, 17'h02000);
    add(enc_r(5'b01010, 5'd7, 5'd2, 5'd1),        0,0,0, 0, 0,       1, 4, 7,     5,     7,   1, 0, 0, 0, 4'h1, 17'h01000);
    add(enc_i(5'b01011, 5'd8, 5'd1, 17'h3),       0,0,0, 0, 0,       1, 5, 5,     0,     8,   1, 1, 0, 0, 4'h3, 17'h00003);
    add(enc_i(5'b01101, 5'd9, 5'd6, 17'h2004),    0,0,0, 0, 0,       1, 7, 32'h33,7,     9,   1, 1, 0, 0, 4'h1, 17'h02004);
    add(enc_i(5'b01100, 5'd9, 5'd1, 17'h1001),    0,0,0, 0, 0,       1, 6, 5,     5,     9,   1, 1, 0, 0, 4'h1, 17'h01001);
    add(enc_r(5'b00100, 5'd10, 5'd1, 5'd0),       0,0,0, 0, 0,       1, 0, 5,     0,     10,  1, 0, 1, 0, 4'h0, 17'h00000);
    add(enc_i(5'b00101, 5'd2, 5'd1, 17'h5),       0,0,0, 0, 0,       1, 0, 5,     7,     2,   0, 1, 0, 1, 4'h0, 17'h00005);
    add(enc_r(5'b00110, 5'd11, 5'd6, 5'd2),       0,0,0, 0, 0,       1, 0, 32'h33,0,     11,  1, 0, 0, 0, 4'h0, 17'h02000);
    add(enc_i(5'b00111, 5'd12, 5'd1, 17'h02abc),  0,0,0, 0, 0,       1, 0, 0,     7,     12,  1, 1, 0, 0, 4'h0, 17'h02abc);
    add({5'b10010, 27'h0},                        0,0,0, 0, 0,       1, 0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h00000);
    add(enc_b(3'b111, 22'h12345),                 0,0,0, 1, 22'h12345,0,0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b011, 22'h00abc),                 0,1,0, 1, 22'h00abc,0,0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b010, 22'h00abc),                 0,1,0, 0, 0,       0, 0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b110, 22'h3ffff),                 0,0,1, 1, 22'h3ffff,0,0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b001, 22'h00010),                 0,0,0, 0, 0,       0, 0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b000, 22'h00001),                 0,0,0, 1, 22'h00001,0,0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b100, 22'h00002),                 0,1,0, 0, 0,       0, 0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_b(3'b101, 22'h00003),                 1,0,0, 1, 22'h00003,0,0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);
    add(enc_r(5'b10000, 5'd6, 5'd0, 5'd0),        0,0,0, 1, 22'h33,   0, 0, 0,     0,     0,   0, 0, 0, 0, 4'h0, 17'h0);

    // reset state
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_taken", bus.branch_taken, 0);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ras_count", bus.ras_count, 0);
    chk("rst_halted", bus.halted, 0);
    tick();
    rst_n = 1'b1;

    wb_write(5'd1, 32'h5);
    wb_write(5'd2, 32'h7);
    wb_write(5'd6, 32'h33);
    wb_write(5'd29, 32'h77);

    foreach (vq[i]) begin
      bus.instr = vq[i].instr; bus.pc_in = ADDR_W'(i + 16); bus.instr_valid = 1'b1;
      bus.ex_zero = vq[i].z; bus.ex_neg = vq[i].n; bus.ex_ov = vq[i].v;
      #1;
      chk($sformatf("v%0d_stall", i), bus.stall, 0);
      chk($sformatf("v%0d_taken", i), bus.branch_taken, vq[i].taken);
      if (vq[i].taken) chk($sformatf("v%0d_baddr", i), bus.branch_addr, vq[i].baddr);
      tick();
      chk($sformatf("v%0d_ex_valid", i), bus.ex_valid, vq[i].valid);
      if (vq[i].valid) begin
        chk($sformatf("v%0d_pc", i), bus.ex_pc, i + 16);
        chk($sformatf("v%0d_alu", i), bus.ex_alu_op, vq[i].alu);
        chk($sformatf("v%0d_s", i), bus.ex_s_data, vq[i].s);
        chk($sformatf("v%0d_t", i), bus.ex_t_data, vq[i].t);
        chk($sformatf("v%0d_dst", i), bus.ex_dst_reg, vq[i].dst);
        chk($sformatf("v%0d_ctl", i),
            {bus.ex_use_dst_reg, bus.ex_use_imm, bus.ex_mem_re, bus.ex_mem_we},
            {vq[i].ud, vq[i].ui, vq[i].re, vq[i].we});
        chk($sformatf("v%0d_upd", i), bus.ex_upd_flags, vq[i].upd);
        chk($sformatf("v%0d_imm", i), bus.ex_imm, vq[i].imm);
      end
    end
    bus.ex_zero = 1'b0; bus.ex_neg = 1'b0; bus.ex_ov = 1'b0;

    // write-back bypass and r0 write immunity
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'hAA;
    bus.instr = enc_i(5'b00001, 5'd3, 5'd1, 17'h0);
    tick();
    chk("byp_same_cycle", bus.ex_s_data, 32'hAA);
    bus.wb_we = 1'b0; bus.instr = enc_r(5'b00000, 5'd3, 5'd1, 5'd0);
    tick();
    chk("byp_written", bus.ex_s_data, 32'hAA);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
    bus.instr = enc_r(5'b00000, 5'd3, 5'd0, 5'd0);
    tick();
    chk("r0_bypass", bus.ex_s_data, 0);
    bus.wb_we = 1'b0;
    tick();
    chk("r0_stored", bus.ex_s_data, 0);

    // load-use hazard: one bubble, then the consumer issues
    bus.instr = enc_r(5'b00100, 5'd4, 5'd1, 5'd0);
    tick();
    bus.instr = enc_r(5'b00000, 5'd5, 5'd4, 5'd1);
    #1;
    chk("lu_stall", bus.stall, 1);
    tick();
    chk("lu_bubble", bus.ex_valid, 0);
    #1;
    chk("lu_stall_clear", bus.stall, 0);
    tick();
    chk("lu_issue_valid", bus.ex_valid, 1);
    chk("lu_issue_dst", bus.ex_dst_reg, 5);
    bus.instr = enc_r(5'b00100, 5'd0, 5'd1, 5'd0);
    tick();
    bus.instr = enc_r(5'b00000, 5'd5, 5'd0, 5'd1);
    #1;
    chk("lu_r0_nostall", bus.stall, 0);
    tick();
    chk("lu_r0_valid", bus.ex_valid, 1);

    // RAS: five pushes into four entries, then five returns
    for (int i = 1; i <= 5; i++) begin
      bus.instr = enc_jal(22'h100 + 22'(i)); bus.next_pc = ADDR_W'(i);
      #1;
      chk($sformatf("jal%0d_taken", i), bus.branch_taken, 1);
      chk($sformatf("jal%0d_addr", i), bus.branch_addr, 22'h100 + 22'(i));
      tick();
      chk($sformatf("jal%0d_count", i), bus.ras_count, (i > 4) ? 4 : i);
      chk($sformatf("jal%0d_ex_valid", i), bus.ex_valid, 0);
    end
    bus.instr = enc_r(5'b10000, 5'd29, 5'd0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("ret%0d_taken", k), bus.branch_taken, 1);
      chk($sformatf("ret%0d_addr", k), bus.branch_addr, 5 - k);
      tick();
      chk($sformatf("ret%0d_count", k), bus.ras_count, 3 - k);
      chk($sformatf("ret%0d_unf", k), bus.ras_underflow, 0);
    end
    #1;
    chk("ret4_taken", bus.branch_taken, 1);
    chk("ret4_fallback", bus.branch_addr, 22'h77);
    tick();
    chk("ret4_unf", bus.ras_underflow, 1);
    chk("ret4_count", bus.ras_count, 0);
    bus.instr_valid = 1'b0;
    tick();
    chk("unf_pulse_end", bus.ras_underflow, 0);

    // flush squashes branch and issue
    bus.instr_valid = 1'b1; bus.flush = 1'b1;
    bus.instr = enc_b(3'b011, 22'h2222); bus.ex_neg = 1'b1; bus.ex_zero = 1'b0;
    #1;
    chk("flush_taken", bus.branch_taken, 0);
    tick();
    chk("flush_b_valid", bus.ex_valid, 0);
    bus.instr = enc_r(5'b00000, 5'd3, 5'd1, 5'd2);
    tick();
    chk("flush_add_valid", bus.ex_valid, 0);
    bus.flush = 1'b0;
    tick();
    chk("noflush_add_valid", bus.ex_valid, 1);
    bus.instr = enc_b(3'b011, 22'h2222);
    #1;
    chk("noflush_taken", bus.branch_taken, 1);
    chk("noflush_addr", bus.branch_addr, 22'h2222);
    tick();
    bus.ex_neg = 1'b0;

    // HALT is sticky and blocks later actions
    bus.instr = enc_jal(22'h5); bus.next_pc = 22'h9;
    tick();
    chk("pre_halt_count", bus.ras_count, 1);
    bus.instr = {5'b11111, 5'd7, 22'h0};
    #1;
    chk("halt_pre_stall", bus.stall, 0);
    tick();
    chk("halted_set", bus.halted, 1);
    chk("halt_stall", bus.stall, 1);
    chk("halt_ex_valid", bus.ex_valid, 0);
    chk("halt_dst", bus.ex_dst_reg, 7);
    bus.instr = enc_jal(22'h6);
    #1;
    chk("halted_no_taken", bus.branch_taken, 0);
    tick();
    chk("halted_no_push", bus.ras_count, 1);
    chk("halted_ex_valid", bus.ex_valid, 0);
    chk("halted_sticky", bus.halted, 1);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halted", bus.halted, 0);
    chk("arst_stall", bus.stall, 0);
    chk("arst_taken", bus.branch_taken, 0);
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_count", bus.ras_count, 0);
    chk("arst_dst", bus.ex_dst_reg, 0);
    chk("arst_unf", bus.ras_underflow, 0);
    tick();
    rst_n = 1'b1;
    bus.instr = enc_r(5'b00000, 5'd3, 5'd1, 5'd2);
    tick();
    chk("post_rst_valid", bus.ex_valid, 1);
    chk("post_rst_regs", {bus.ex_s_data, bus.ex_t_data}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
